// File: rtl/bs_rr_arbiter_pkg.sv
// Shared state encoding, header layout and header decode helpers for the bus arbiter.
// Combinational helpers only; no timing or backpressure of its own.
package bs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    ROUTE = 2'd2
  } state_t;

  localparam int PCKG_SZ_DEF = 128;
  localparam logic [7:0] BROADCAST_DEF = 8'hFF;

  // Header occupies the top 32 bits of any packet width: target, source, id.
  localparam int HDR_W       = 32;
  localparam int HDR_TGT_LSB = HDR_W - 8;
  localparam int HDR_SRC_LSB = HDR_W - 16;
  localparam int HDR_ID_LSB  = HDR_W - 32;

  function automatic logic [7:0] get_target(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_TGT_LSB +: 8];
  endfunction

  function automatic logic [7:0] get_source(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_SRC_LSB +: 8];
  endfunction

  function automatic logic [15:0] get_id(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_ID_LSB +: 16];
  endfunction

endpackage

// File: rtl/bs_rr_pick.sv
// Round-robin search: first pending driver after i_ptr, wrapping by explicit modulo.
// Purely combinational; no backpressure.
module bs_rr_pick
  import bs_pkg::*;
#(
  parameter int DRVRS = 4,
  parameter int IDX_W = $clog2(DRVRS)
) (
  input  logic [DRVRS-1:0] i_pndng,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  // Walk from farthest to nearest so the nearest pending candidate wins.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int k = DRVRS; k >= 1; k--) begin
      if (i_pndng[(int'(i_ptr) + k) % DRVRS]) begin
        o_idx = IDX_W'((int'(i_ptr) + k) % DRVRS);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bs_rr_arbiter.sv
// Round-robin bus scheduler: grant, pop, route; pndng-to-push in 3 edges, 3 cycles/packet minimum.
// Waits in ROUTE while any destination is full (no partial broadcast); BS_ARB_STATS_EN adds pkt_cnt.
module bs_rr_arbiter
  import bs_pkg::*;
#(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = PCKG_SZ_DEF,
  parameter logic [7:0] BROADCAST = BROADCAST_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  input  logic [DRVRS-1:0]                full,
  output logic [DRVRS-1:0]                push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
  output logic [DRVRS-1:0]                grnt,
  output logic                            busy,
  output logic                            drop
`ifdef BS_ARB_STATS_EN
  ,
  output logic [DRVRS-1:0][15:0]          pkt_cnt
`endif
);

  localparam int IDX_W = $clog2(DRVRS);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_pick_idx;
  logic               w_pick_vld;
  logic [PCKG_SZ-1:0] r_pkt, r_dpush;
  logic [7:0]         w_tgt;
  logic [DRVRS-1:0]   w_mask;
  logic               w_bad, w_blocked;
  logic [DRVRS-1:0]   r_pop, r_push, r_grnt;
  logic [DRVRS-1:0]   w_pop_nxt, w_push_nxt, w_grnt_nxt;
  logic               r_busy, r_drop, w_drop_nxt;

  bs_rr_pick #(.DRVRS(DRVRS), .IDX_W(IDX_W)) u_pick (
    .i_pndng (pndng),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_vld   (w_pick_vld)
  );

  assign w_tgt = get_target(r_pkt[PCKG_SZ-1 -: HDR_W]);

  // r_ptr doubles as the index of the driver being served.
  always_comb begin
    w_mask = '0;
    w_bad  = 1'b0;
    if (w_tgt == BROADCAST) begin
      w_mask        = '1;
      w_mask[r_ptr] = 1'b0;
    end else if ((int'(w_tgt) < DRVRS) && (IDX_W'(w_tgt) != r_ptr)) begin
      w_mask[IDX_W'(w_tgt)] = 1'b1;
    end else begin
      w_bad = 1'b1;
    end
  end

  assign w_blocked = (w_mask & full) != '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = POP;
      POP:     w_state_nxt = ROUTE;
      ROUTE:   if (w_bad || !w_blocked) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pop_nxt  = '0;
    w_push_nxt = '0;
    w_drop_nxt = 1'b0;
    w_grnt_nxt = r_grnt;
    case (r_state)
      IDLE: begin
        w_grnt_nxt = '0;
        if (w_pick_vld) w_grnt_nxt[w_pick_idx] = 1'b1;
      end
      POP:  w_pop_nxt = r_grnt;
      ROUTE: begin
        if (w_bad) begin
          w_drop_nxt = 1'b1;
          w_grnt_nxt = '0;
        end else if (!w_blocked) begin
          w_push_nxt = w_mask;
          w_grnt_nxt = '0;
        end
      end
      default: w_grnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= IDX_W'(DRVRS - 1);
      r_pkt   <= '0;
      r_dpush <= '0;
      r_pop   <= '0;
      r_push  <= '0;
      r_grnt  <= '0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_pop  <= w_pop_nxt;
      r_push <= w_push_nxt;
      r_grnt <= w_grnt_nxt;
      r_drop <= w_drop_nxt;
      r_busy <= (w_state_nxt != IDLE);
      if (r_state == IDLE && w_pick_vld) r_ptr <= w_pick_idx;
      if (r_state == POP) r_pkt <= D_pop[r_ptr];
      if (w_push_nxt != '0) r_dpush <= r_pkt;
    end
  end

  assign pop  = r_pop;
  assign push = r_push;
  assign grnt = r_grnt;
  assign busy = r_busy;
  assign drop = r_drop;

  always_comb begin
    for (int l = 0; l < DRVRS; l++) D_push[l] = r_dpush;
  end

`ifdef BS_ARB_STATS_EN
  logic [DRVRS-1:0][15:0] r_pkt_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  r_pkt_cnt <= '0;
    else if (w_push_nxt != '0)  r_pkt_cnt[r_ptr] <= r_pkt_cnt[r_ptr] + 16'd1;
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_bs_rr_arbiter.sv
// Directed bench for bs_rr_arbiter: a 2-driver and a 4-driver instance on a shared clock/reset.
module tb_bs_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [1:0]        pndng2, pop2, full2, push2, grnt2;
  logic              busy2, drop2;
  logic [1:0][127:0] dpop2, dpush2;

  logic [3:0]        pndng4, pop4, full4, push4, grnt4;
  logic              busy4, drop4;
  logic [3:0][127:0] dpop4, dpush4;

`ifdef BS_ARB_STATS_EN
  logic [1:0][15:0] cnt2;
  logic [3:0][15:0] cnt4;
`endif

  int checks = 0;
  int errors = 0;
  int ids [2];

  bs_rr_arbiter #(.DRVRS(2)) u2 (
    .clk(clk), .reset(reset), .pndng(pndng2), .D_pop(dpop2), .pop(pop2),
    .full(full2), .push(push2), .D_push(dpush2), .grnt(grnt2), .busy(busy2), .drop(drop2)
`ifdef BS_ARB_STATS_EN
    , .pkt_cnt(cnt2)
`endif
  );

  bs_rr_arbiter #(.DRVRS(4)) u4 (
    .clk(clk), .reset(reset), .pndng(pndng4), .D_pop(dpop4), .pop(pop4),
    .full(full4), .push(push4), .D_push(dpush4), .grnt(grnt4), .busy(busy4), .drop(drop4)
`ifdef BS_ARB_STATS_EN
    , .pkt_cnt(cnt4)
`endif
  );

  function automatic logic [127:0] pkt(input logic [7:0] t, input logic [7:0] s, input logic [15:0] id);
    return {t, s, id, 96'h5A5A_0000_1234_5678_9ABC_DEF0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    pndng2 = '0; full2 = '0; dpop2 = '0;
    pndng4 = '0; full4 = '0; dpop4 = '0;
    do_reset();

    // Reset state
    chk("rst_pop2",   32'(pop2), 0);
    chk("rst_push2",  32'(push2), 0);
    chk("rst_grnt2",  32'(grnt2), 0);
    chk("rst_busy2",  32'(busy2), 0);
    chk("rst_drop2",  32'(drop2), 0);
    chk("rst_dpush2", dpush2[1][127:96], 0);
    chk("rst_dpush4", dpush4[3][127:96], 0);

    // Single packet driver 0 -> 1
    dpop2[0] = pkt(8'd1, 8'd0, 16'd0);
    pndng2   = 2'b01;
    tick(); chk("t1_grnt", 32'(grnt2), 1); chk("t1_pop_early", 32'(pop2), 0); chk("t1_busy", 32'(busy2), 1);
    tick(); chk("t1_pop", 32'(pop2), 1);   chk("t1_push_early", 32'(push2), 0);
    tick(); chk("t1_push", 32'(push2), 2); chk("t1_dpush", dpush2[1][127:96], 32'h0100_0000);
    chk("t1_grnt_idle", 32'(grnt2), 0); chk("t1_busy_idle", 32'(busy2), 0); chk("t1_pop_off", 32'(pop2), 0);
    pndng2 = 2'b00;
    tick(); chk("t1_push_off", 32'(push2), 0);

    // Alternation under continuous requests
    do_reset();
    ids[0] = 0; ids[1] = 0;
    dpop2[0] = pkt(8'd1, 8'd0, 16'd0);
    dpop2[1] = pkt(8'd0, 8'd1, 16'd0);
    pndng2   = 2'b11;
    for (int n = 0; n < 4; n++) begin
      int d;
      d = n % 2;
      tick(); chk("rr_grnt", 32'(grnt2), 1 << d); chk("rr_pop_idle", 32'(pop2), 0);
      tick(); chk("rr_pop", 32'(pop2), 1 << d);
      tick(); chk("rr_push", 32'(push2), 1 << (1 - d));
      chk("rr_id", 32'(dpush2[1-d][111:96]), ids[d]);
      ids[d]++;
      dpop2[d] = pkt(8'(1 - d), 8'(d), 16'(ids[d]));
    end

    // Backpressure: full[1] holds the packet in ROUTE
    pndng2 = 2'b01;
    full2  = 2'b10;
    tick(); chk("bp_grnt", 32'(grnt2), 1);
    tick(); chk("bp_pop", 32'(pop2), 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_push_hold", 32'(push2), 0);
      chk("bp_pop_hold", 32'(pop2), 0);
      chk("bp_busy_hold", 32'(busy2), 1);
      chk("bp_grnt_hold", 32'(grnt2), 1);
    end
    full2 = 2'b00;
    tick(); chk("bp_push", 32'(push2), 2); chk("bp_id", 32'(dpush2[1][111:96]), ids[0]);
    pndng2 = 2'b00;
    tick(); chk("bp_push_off", 32'(push2), 0);

    // Broadcast from driver 2 of 4
    dpop4[2] = pkt(8'hFF, 8'd2, 16'd7);
    pndng4   = 4'b0100;
    tick(); chk("bc_grnt", 32'(grnt4), 4);
    tick(); chk("bc_pop", 32'(pop4), 4);
    tick(); chk("bc_push", 32'(push4), 32'b1011); chk("bc_dpush3", dpush4[3][127:96], 32'hFF02_0007);
    chk("bc_dpush0", dpush4[0][127:96], 32'hFF02_0007);
    dpop4[2] = pkt(8'hFF, 8'd2, 16'd8);
    full4    = 4'b1000;
    tick(); chk("bc_push_off", 32'(push4), 0); chk("bc2_grnt", 32'(grnt4), 4);
    tick(); chk("bc2_pop", 32'(pop4), 4);
    for (int c = 0; c < 3; c++) begin
      tick(); chk("bc2_push_hold", 32'(push4), 0); chk("bc2_busy", 32'(busy4), 1);
    end
    full4 = 4'b0000;
    tick(); chk("bc2_push", 32'(push4), 32'b1011); chk("bc2_id", 32'(dpush4[1][111:96]), 8);
    dpop4[2] = pkt(8'd5, 8'd2, 16'd9);
    tick(); chk("bc2_push_off", 32'(push4), 0);

    // Drops: out-of-range target, then self-target
    tick(); chk("dr1_pop", 32'(pop4), 4);
    tick(); chk("dr1_drop", 32'(drop4), 1); chk("dr1_push", 32'(push4), 0); chk("dr1_busy", 32'(busy4), 0);
    dpop4[2] = pkt(8'd2, 8'd2, 16'd10);
    tick(); chk("dr1_drop_off", 32'(drop4), 0); chk("dr2_grnt", 32'(grnt4), 4);
    tick(); chk("dr2_pop", 32'(pop4), 4);
    tick(); chk("dr2_drop", 32'(drop4), 1); chk("dr2_push", 32'(push4), 0); chk("dr2_busy", 32'(busy4), 0);
    pndng4 = 4'b0000;
    tick(); chk("dr2_drop_off", 32'(drop4), 0); chk("dr2_busy_off", 32'(busy4), 0);
    chk("dr2_push_off", 32'(push4), 0);

    // Reset while a packet sits in ROUTE
    dpop4[0] = pkt(8'd1, 8'd0, 16'd11);
    pndng4   = 4'b0001;
    full4    = 4'b0010;
    tick(); chk("mr_grnt", 32'(grnt4), 1);
    tick(); chk("mr_pop", 32'(pop4), 1);
    tick(); chk("mr_route_push", 32'(push4), 0);
    reset = 1'b1;
    #1;
    chk("mr_push", 32'(push4), 0); chk("mr_pop0", 32'(pop4), 0);
    chk("mr_grnt0", 32'(grnt4), 0); chk("mr_busy0", 32'(busy4), 0);
    full4 = 4'b0000;
    tick(); chk("mr_push_rst", 32'(push4), 0);
    tick(); chk("mr_push_rst2", 32'(push4), 0);
    reset  = 1'b0;
    pndng4 = 4'b1001;
    tick(); chk("mr_first_grnt", 32'(grnt4), 1); chk("mr_push_after", 32'(push4), 0);
    pndng4 = 4'b0000;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bs_rr_arbiter.md
Name: bs_rr_arbiter

Overview:
Round-robin scheduler for the shared serial/parallel bus. It sits between DRVRS driver FIFOs (pop side) and DRVRS receive FIFOs (push side).
- Picks one pending driver, pops its head packet and decodes the 8-bit target field.
- Delivers the packet to one destination FIFO, or to all other drivers on broadcast, honouring per-destination full backpressure.

Parameters:
DRVRS, 4, number of drivers/ports (2..16)
PCKG_SZ, 128, packet width in bits; header = target[PCKG_SZ-1 -: 8], source[PCKG_SZ-9 -: 8], id[PCKG_SZ-17 -: 16]
BROADCAST, 8'hFF, target value meaning "all drivers except source"

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pndng  in  DRVRS  driver FIFO i non-empty; D_pop[i] valid while high
D_pop  in  [DRVRS][PCKG_SZ]  head packet of driver FIFO i
pop  out  DRVRS  one-cycle pop strobe to driver FIFO i
full  in  DRVRS  receive FIFO i cannot accept a push
push  out  DRVRS  one-cycle push strobe to receive FIFO i
D_push  out  [DRVRS][PCKG_SZ]  packet to receive FIFO i; all lanes carry the same latched packet
grnt  out  DRVRS  one-hot index of the driver currently being served; 0 in IDLE
busy  out  1  high in any state other than IDLE
drop  out  1  one-cycle pulse when a popped packet is discarded

Behaviour:
- All outputs are registered. Reset values:
  - state = IDLE; pop = push = grnt = 0; busy = drop = 0; D_push lanes = 0.
  - Round-robin pointer ptr = DRVRS-1, so driver 0 is granted first.
- IDLE:
  - If pndng != 0, select the first i with pndng[i]=1, searching from ptr+1 modulo DRVRS.
  - Set grnt = onehot(i) and ptr = i, then go to POP.
  - If pndng == 0, stay in IDLE.
- POP (1 cycle):
  - pop[i] = 1 for exactly this cycle.
  - Latch D_pop[i] into the packet register on the same edge.
  - pndng changes during POP are ignored; the FIFO contract holds pndng until the pop.
  - Next state: ROUTE.
- ROUTE: compute the destination mask m.
  - target == BROADCAST: m = all ones except bit i.
  - target < DRVRS and target != i: m = onehot(target).
  - Otherwise (out of range or self-target): pulse drop, no push, go to IDLE.
  - If (m & full) != 0, stay in ROUTE; there is no timeout and no partial broadcast.
  - Else, on the next cycle push = m for exactly one cycle, D_push = the latched packet, then go to IDLE.
- Timing:
  - Latency from pndng sampled in IDLE to push is 3 edges: grant edge, pop edge, push edge.
  - Minimum 3 cycles per packet; grnt is held through POP and ROUTE.
- Fairness: the last-served driver has the lowest priority on the next arbitration; there is no starvation under continuous requests.
- Reset mid-operation: a packet already popped but not yet pushed is lost; all strobes deassert immediately.
- DRVRS must be a power of two or not; index wrap is explicit modulo, never bit truncation.

Optional Feature:
BS_ARB_STATS_EN
- Defined: adds output pkt_cnt [DRVRS][16].
  - pkt_cnt[i] increments on each successful push of a packet sourced from driver i.
  - A broadcast counts as 1. Counts wrap 16'hFFFF -> 0; reset value 0.
  - Dropped packets are not counted.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package bs_pkg holds:
  - the state enum (IDLE, POP, ROUTE);
  - header field offset localparams derived from PCKG_SZ;
  - functions get_target and get_source;
  - the BROADCAST default.
- One sub-module, bs_rr_pick: combinational next-index search over pndng given ptr; outputs index and valid.

Test Plan:
- DRVRS=2, reset, pndng=2'b01, D_pop[0]=target 1/src 0/id 0 -> pop[0] one cycle after grant; push=2'b10 next cycle; D_push[1][127:96]=32'h0100_0000.
- pndng=2'b11 held high, ids incrementing per pop -> grnt alternates 01,10,01,10; pop pulses every 3 cycles; ids are received in order on each side.
- full[1]=1 for 5 cycles during ROUTE -> state holds, push=0, no further pop; push[1] pulses on the cycle after full[1] falls.
- DRVRS=4, driver 2 sends target 8'hFF -> push=4'b1011 for one cycle; with full[3]=1 no lane pushes until full[3] falls.
- DRVRS=4, target 8'd5, then target = own index -> drop pulses once each; push stays 0; busy returns to 0.
- Reset asserted while in ROUTE -> push never pulses, outputs are 0; after release, driver 0 is granted first.
